axi_rd_master: RTL and testbench
================================

# axi_rd_master

AXI4 read-burst master that turns a single cache-line refill request into one incrementing AXI read burst and returns the assembled line. It sits directly upstream of the SRAM-backed AXI read slave in the perip/mem verification subsystem. It drives AR, collects R beats into a line buffer, and presents the full line to the requester with an error flag.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per line; power of 2, range 2..8.
- ADDR_W, 32: address width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  refill request valid.
- req_addr_i  in  ADDR_W  any byte address inside the target line.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- resp_valid_o  out  1  line available.
- resp_line_o  out  32*LINE_WORDS  line data; word k at bits [32k+31:32k].
- resp_err_o  out  1  burst error (see Operation).
- resp_ready_i  in  1  requester consumes the line.
- axi_araddr_o  out  32  line-aligned burst address.
- axi_arlen_o  out  8  constant LINE_WORDS-1.
- axi_arvalid_o  out  1  AR valid.
- axi_arready_i  in  1  AR ready.
- axi_rdata_i  in  32  read data.
- axi_rresp_i  in  2  read response.
- axi_rlast_i  in  1  last beat.
- axi_rvalid_i  in  1  R valid.
- axi_rready_o  out  1  R ready.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch the address with its low log2(LINE_WORDS*4) bits cleared, clear the beat counter and the error flag, and go to ADDR.
- ADDR: axi_arvalid_o=1, and axi_araddr_o is stable. On axi_arready_i, go to DATA.
- DATA: axi_rready_o=1. Each beat with axi_rvalid_i writes axi_rdata_i to buffer word[cnt], then cnt increments.
  - The beat is final if axi_rlast_i=1 or cnt==LINE_WORDS-1. On the final beat, go to RESP.
- Error flag is set sticky by any of:
  - axi_rresp_i!=2'b00 on any beat;
  - axi_rlast_i=1 while cnt<LINE_WORDS-1 (short burst);
  - cnt==LINE_WORDS-1 without axi_rlast_i (long burst). The slave's extra beats are not absorbed; the bench must treat this as a protocol violation.
- Unfilled words after a short burst hold their previous contents.
- RESP: resp_valid_o=1, with resp_line_o and resp_err_o stable. On resp_ready_i, go to IDLE.
- Only one request is outstanding at a time. No new AR is issued before RESP completes.
- Reset, including mid-burst: async return to IDLE. Counter, flag and buffer are cleared. In-flight R beats are dropped.

## Timing
- Reset values:
  - req_ready_o=1
  - axi_arvalid_o=0
  - axi_rready_o=0
  - resp_valid_o=0
  - resp_err_o=0
  - axi_araddr_o=0
  - resp_line_o=0
- axi_arlen_o is constant.
- All outputs are registered or decoded from state only; there is no combinational in-to-out path.
- Accept at cycle 0. ARVALID rises at cycle 1.
- With ARREADY at cycle 1 and back-to-back beats, beats arrive at cycles 2..LINE_WORDS+1 and resp_valid_o rises at cycle LINE_WORDS+2.
- ARVALID stays high and axi_araddr_o stays constant until the handshake.
- R stall (rvalid low) inserts wait cycles with no data written.
- resp_valid_o held with resp_ready_i low: line and err stay stable indefinitely.
- resp_ready_i in the same cycle resp_valid_o rises: IDLE on the next cycle; a new request may be accepted there.

## Configuration
- AXI_RD_MASTER_TIMEOUT_EN defined:
  - An 8-bit idle counter runs in ADDR and DATA. It resets on each AR handshake or accepted beat.
  - On reaching 255, the master sets resp_err_o and forces RESP.
  - axi_arvalid_o and axi_rready_o drop on entry to RESP.
- Undefined: no counter exists, and ADDR/DATA wait indefinitely.

## Structure
- Shared package axi_rd_pkg holds:
  - the state encoding: IDLE=0, ADDR=1, DATA=2, RESP=3;
  - AXI_RESP_OKAY=2'b00;
  - the timeout limit constant 255.
- Sub-module axi_rd_watchdog holds the timeout counter (inputs: kick, enable; output: expire). It is instantiated only under AXI_RD_MASTER_TIMEOUT_EN.

## Test plan
- Basic burst:
  - Stimulus: req_addr_i=0x1000_0014 with LINE_WORDS=4; slave returns 0xA0..0xA3 with OKAY, rlast on beat 3.
  - Required: axi_araddr_o=0x1000_0010, axi_arlen_o=3, resp_line_o={A3,A2,A1,A0}, resp_err_o=0, resp_valid_o at cycle 6.
- Stalls:
  - Stimulus: ARREADY delayed 3 cycles; rvalid gapped 1-0-1-0.
  - Required: araddr held stable during the AR wait; line correct; resp_valid_o at cycle 12.
- Error response:
  - Stimulus: beat 2 returns rresp=2'b10.
  - Required: all 4 words captured, resp_err_o=1.
- Short burst:
  - Stimulus: rlast on beat 1.
  - Required: RESP after 2 beats, resp_err_o=1, words 2..3 unchanged.
- Reset and back-pressure:
  - Stimulus: rstn_i low during beat 2, then a new request.
  - Required: all outputs at reset values; the new burst completes normally.
  - Stimulus: resp_ready_i held low 10 cycles.
  - Required: line and err stable for all 10 cycles.
- Timeout (AXI_RD_MASTER_TIMEOUT_EN defined):
  - Stimulus: axi_arready_i never asserted.
  - Required: resp_valid_o=1 with resp_err_o=1 after 255 wait cycles; axi_arvalid_o=0 afterwards.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared state encoding and constants for the AXI line-refill read master
package axi_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } rd_state_e;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

   // Number of byte-offset bits inside one line of 32-bit words.
   function automatic int unsigned line_offset_bits(input int unsigned line_words);
      return $clog2(line_words * 4);
   endfunction

endpackage

// File: rtl/axi_rd_master_if.sv
// rtl/axi_rd_master_if.sv - refill request/response and AXI read channel bundle
interface axi_rd_master_if #(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) ();

   logic                      req_valid_i;
   logic [ADDR_W-1:0]         req_addr_i;
   logic                      req_ready_o;
   logic                      resp_valid_o;
   logic [32*LINE_WORDS-1:0]  resp_line_o;
   logic                      resp_err_o;
   logic                      resp_ready_i;
   logic [ADDR_W-1:0]         axi_araddr_o;
   logic [7:0]                axi_arlen_o;
   logic                      axi_arvalid_o;
   logic                      axi_arready_i;
   logic [31:0]               axi_rdata_i;
   logic [1:0]                axi_rresp_i;
   logic                      axi_rlast_i;
   logic                      axi_rvalid_i;
   logic                      axi_rready_o;

   modport master (
      input  req_valid_i, req_addr_i, resp_ready_i,
      input  axi_arready_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
      output req_ready_o, resp_valid_o, resp_line_o, resp_err_o,
      output axi_araddr_o, axi_arlen_o, axi_arvalid_o, axi_rready_o
   );

   modport slave (
      output req_valid_i, req_addr_i, resp_ready_i,
      output axi_arready_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
      input  req_ready_o, resp_valid_o, resp_line_o, resp_err_o,
      input  axi_araddr_o, axi_arlen_o, axi_arvalid_o, axi_rready_o
   );

endinterface

// File: rtl/axi_rd_watchdog.sv
// rtl/axi_rd_watchdog.sv - idle-cycle watchdog for the read master's address and data phases
module axi_rd_watchdog
   import axi_rd_pkg::*;
(
   input  logic clk_i,
   input  logic rstn_i,
   input  logic enable_i,
   input  logic kick_i,
   output logic expire_o
);

   logic [7:0] idle_q, idle_d;

   // Count idle cycles; any progress or leaving the wait phases restarts the count.
   always_comb begin
      idle_d = idle_q;
      if (!enable_i || kick_i) begin
         idle_d = '0;
      end else if (idle_q != TIMEOUT_LIMIT) begin
         idle_d = idle_q + 8'd1;
      end
   end

   // Idle counter register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign expire_o = enable_i && (idle_q == TIMEOUT_LIMIT);

endmodule

// File: rtl/axi_rd_master.sv
// rtl/axi_rd_master.sv - AXI4 read-burst line refill master; AXI_RD_MASTER_TIMEOUT_EN adds an idle watchdog
module axi_rd_master
   import axi_rd_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   axi_rd_master_if.master bus
);

   localparam int                CNT_W     = $clog2(LINE_WORDS);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << line_offset_bits(LINE_WORDS);

   rd_state_e                   state_q, state_d;
   logic [ADDR_W-1:0]           addr_q, addr_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        err_q, err_d;
   logic [LINE_WORDS-1:0][31:0] line_q, line_d;

   logic ar_hs;
   logic r_beat;
   logic r_final;
   logic timeout;

   assign ar_hs   = (state_q == ST_ADDR) && bus.axi_arready_i;
   assign r_beat  = (state_q == ST_DATA) && bus.axi_rvalid_i;
   assign r_final = bus.axi_rlast_i || (cnt_q == LAST_IDX);

`ifdef AXI_RD_MASTER_TIMEOUT_EN
   logic wd_expire;

   axi_rd_watchdog u_watchdog (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .enable_i ((state_q == ST_ADDR) || (state_q == ST_DATA)),
      .kick_i   (ar_hs || r_beat),
      .expire_o (wd_expire)
   );

   // Progress in the expiring cycle wins over the timeout.
   assign timeout = wd_expire && !ar_hs && !r_beat;
`else
   assign timeout = 1'b0;
`endif

   // State register; reset aborts any burst in flight.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one request at a time, address phase, beat collection, line hand-off.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.req_valid_i) state_d = ST_ADDR;
         ST_ADDR: begin
            if (ar_hs)        state_d = ST_DATA;
            else if (timeout) state_d = ST_RESP;
         end
         ST_DATA: begin
            if (r_beat) begin
               if (r_final) state_d = ST_RESP;
            end else if (timeout) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: if (bus.resp_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: line-aligned address, beat index, sticky error, line buffer.
   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      line_d = line_q;
      if ((state_q == ST_IDLE) && bus.req_valid_i) begin
         addr_d = bus.req_addr_i & LINE_MASK;
         cnt_d  = '0;
         err_d  = 1'b0;
      end
      if (r_beat) begin
         line_d[cnt_q] = bus.axi_rdata_i;
         cnt_d         = cnt_q + CNT_W'(1);
         // bad response, rlast early (short burst) or missing on the last word (long burst)
         if (bus.axi_rresp_i != AXI_RESP_OKAY)            err_d = 1'b1;
         if (bus.axi_rlast_i != (cnt_q == LAST_IDX))      err_d = 1'b1;
      end
      if (timeout) begin
         err_d = 1'b1;
      end
   end

   // Datapath registers; buffer is cleared on reset so the line output starts at zero.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         addr_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         line_q <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         line_q <= line_d;
      end
   end

   // Outputs decoded from state or taken straight from registers.
   always_comb begin
      bus.req_ready_o   = (state_q == ST_IDLE);
      bus.axi_arvalid_o = (state_q == ST_ADDR);
      bus.axi_rready_o  = (state_q == ST_DATA);
      bus.resp_valid_o  = (state_q == ST_RESP);
      bus.axi_araddr_o  = addr_q;
      bus.axi_arlen_o   = 8'(LINE_WORDS - 1);
      bus.resp_line_o   = line_q;
      bus.resp_err_o    = err_q;
   end

endmodule

// File: tb/tb_axi_rd_master.sv
// tb/tb_axi_rd_master.sv - randomized self-checking bench for axi_rd_master against a line-level model
module tb_axi_rd_master;

   localparam int LW = 4;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   axi_rd_master_if #(.LINE_WORDS(LW), .ADDR_W(32)) bus ();

   axi_rd_master #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cycle  = 0;

   logic [31:0] m_line    [LW];
   logic [31:0] beat_data [LW];
   logic [1:0]  beat_resp [LW];
   int          beat_gap  [LW];

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [255:0] model_line();
      logic [255:0] r = '0;
      for (int k = 0; k < LW; k++) r[32*k +: 32] = m_line[k];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_req_ready"},  bus.req_ready_o,   1);
      check_eq({tag, "_arvalid"},    bus.axi_arvalid_o, 0);
      check_eq({tag, "_rready"},     bus.axi_rready_o,  0);
      check_eq({tag, "_resp_valid"}, bus.resp_valid_o,  0);
      check_eq({tag, "_resp_err"},   bus.resp_err_o,    0);
      check_eq({tag, "_araddr"},     bus.axi_araddr_o,  0);
      check_eq({tag, "_line"},       bus.resp_line_o,   0);
   endtask

   // One refill: rlast_pos==LW means rlast never asserted (long burst; master stops after LW beats).
   task automatic run_burst(input logic [31:0] addr, input int ar_delay, input int rlast_pos, input int hold);
      logic [31:0] exp_addr;
      logic        exp_err;
      int          nbeats, gaps, exp_cycle, waited;
      exp_addr = addr & ~32'(LW*4 - 1);
      exp_err  = 1'b0;
      gaps     = 0;
      nbeats   = (rlast_pos < LW) ? rlast_pos + 1 : LW;
      check_eq("req_ready_idle", bus.req_ready_o, 1);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = addr;
      cycle = 0;
      step();
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = $urandom;
      for (int d = 0; d < ar_delay; d++) begin
         check_eq("arvalid_wait", bus.axi_arvalid_o, 1);
         check_eq("araddr_wait", bus.axi_araddr_o, exp_addr);
         step();
      end
      check_eq("arvalid", bus.axi_arvalid_o, 1);
      check_eq("araddr", bus.axi_araddr_o, exp_addr);
      check_eq("arlen", bus.axi_arlen_o, LW - 1);
      bus.axi_arready_i = 1'b1;
      step();
      bus.axi_arready_i = 1'b0;
      check_eq("arvalid_after_hs", bus.axi_arvalid_o, 0);
      for (int b = 0; b < nbeats; b++) begin
         for (int g = 0; g < beat_gap[b]; g++) begin
            bus.axi_rvalid_i = 1'b0;
            check_eq("rready_gap", bus.axi_rready_o, 1);
            step();
            gaps++;
         end
         bus.axi_rvalid_i = 1'b1;
         bus.axi_rdata_i  = beat_data[b];
         bus.axi_rresp_i  = beat_resp[b];
         bus.axi_rlast_i  = (b == rlast_pos);
         check_eq("rready_beat", bus.axi_rready_o, 1);
         step();
         m_line[b] = beat_data[b];
         if (beat_resp[b] != 2'b00) exp_err = 1'b1;
      end
      if (rlast_pos != LW - 1) exp_err = 1'b1;
      bus.axi_rvalid_i = 1'b0;
      bus.axi_rlast_i  = 1'b0;
      exp_cycle = 2 + ar_delay + gaps + nbeats;
      waited = 0;
      while (!bus.resp_valid_o && waited < 20) begin
         step();
         waited++;
      end
      check_eq("resp_cycle", cycle, exp_cycle);
      check_eq("resp_valid", bus.resp_valid_o, 1);
      check_eq("rready_resp", bus.axi_rready_o, 0);
      check_eq("resp_line", bus.resp_line_o, model_line());
      check_eq("resp_err", bus.resp_err_o, exp_err);
      for (int h = 0; h < hold; h++) begin
         step();
         check_eq("hold_valid", bus.resp_valid_o, 1);
         check_eq("hold_line", bus.resp_line_o, model_line());
         check_eq("hold_err", bus.resp_err_o, exp_err);
      end
      bus.resp_ready_i = 1'b1;
      step();
      bus.resp_ready_i = 1'b0;
      check_eq("resp_valid_drop", bus.resp_valid_o, 0);
      check_eq("req_ready_back", bus.req_ready_o, 1);
   endtask

   task automatic set_beats_ok(input logic [31:0] base);
      for (int b = 0; b < LW; b++) begin
         beat_data[b] = base + 32'(b);
         beat_resp[b] = 2'b00;
         beat_gap[b]  = 0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int waited;
      int r;
      rstn = 1'b0;
      bus.req_valid_i   = 1'b0;
      bus.req_addr_i    = '0;
      bus.resp_ready_i  = 1'b0;
      bus.axi_arready_i = 1'b0;
      bus.axi_rdata_i   = '0;
      bus.axi_rresp_i   = 2'b00;
      bus.axi_rlast_i   = 1'b0;
      bus.axi_rvalid_i  = 1'b0;
      for (int k = 0; k < LW; k++) m_line[k] = '0;
      step();
      step();
      check_reset_vals("reset");
      rstn = 1'b1;
      step();

      // basic burst
      set_beats_ok(32'hA0);
      run_burst(32'h1000_0014, 0, LW - 1, 0);

      // AR stall plus gapped R, then long back-pressure on the response
      set_beats_ok(32'hB0);
      for (int b = 1; b < LW; b++) beat_gap[b] = 1;
      run_burst(32'h2000_0008, 3, LW - 1, 10);

      // error response on beat 2
      set_beats_ok(32'hC0);
      beat_resp[2] = 2'b10;
      run_burst(32'h3000_003C, 0, LW - 1, 2);

      // short burst: words 2..3 keep the previous line
      set_beats_ok(32'hD0);
      run_burst(32'h4000_0020, 1, 1, 1);

      // long burst: rlast missing on the last word
      set_beats_ok(32'hE0);
      run_burst(32'h5000_0004, 0, LW, 0);

      // reset in the middle of beat 2
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 32'h6000_0010;
      step();
      bus.req_valid_i   = 1'b0;
      bus.axi_arready_i = 1'b1;
      step();
      bus.axi_arready_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bus.axi_rvalid_i = 1'b1;
         bus.axi_rdata_i  = $urandom;
         step();
      end
      bus.axi_rvalid_i = 1'b1;
      bus.axi_rdata_i  = $urandom;
      #2;
      rstn = 1'b0;
      #1;
      check_reset_vals("midburst_reset");
      step();
      bus.axi_rvalid_i = 1'b0;
      step();
      check_reset_vals("reset_held");
      rstn = 1'b1;
      for (int k = 0; k < LW; k++) m_line[k] = '0;
      step();
      set_beats_ok(32'hF0);
      run_burst(32'h6000_0018, 0, LW - 1, 0);

`ifdef AXI_RD_MASTER_TIMEOUT_EN
      // AR never accepted: watchdog forces an error response
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 32'h7000_0000;
      cycle = 0;
      step();
      bus.req_valid_i = 1'b0;
      waited = 0;
      while (!bus.resp_valid_o && waited < 400) begin
         step();
         waited++;
      end
      check_eq("timeout_cycle_in_range", (cycle >= 256) && (cycle <= 258), 1);
      check_eq("timeout_resp_valid", bus.resp_valid_o, 1);
      check_eq("timeout_err", bus.resp_err_o, 1);
      check_eq("timeout_arvalid", bus.axi_arvalid_o, 0);
      check_eq("timeout_line", bus.resp_line_o, model_line());
      bus.resp_ready_i = 1'b1;
      step();
      bus.resp_ready_i = 1'b0;
      check_eq("timeout_idle", bus.req_ready_o, 1);
`else
      // AR never accepted: master waits indefinitely
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 32'h7000_0000;
      step();
      bus.req_valid_i = 1'b0;
      for (int i = 0; i < 300; i++) step();
      check_eq("no_timeout_arvalid", bus.axi_arvalid_o, 1);
      check_eq("no_timeout_resp_valid", bus.resp_valid_o, 0);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      for (int k = 0; k < LW; k++) m_line[k] = '0;
      step();
`endif

      // randomized bursts
      for (int t = 0; t < 40; t++) begin
         for (int b = 0; b < LW; b++) begin
            beat_data[b] = $urandom;
            beat_resp[b] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            beat_gap[b]  = $urandom_range(0, 2);
         end
         r = $urandom_range(0, 9);
         run_burst($urandom, $urandom_range(0, 3),
                   (r < 7) ? LW - 1 : (r < 9) ? $urandom_range(0, LW - 2) : LW,
                   $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
